// File: rtl/status_stack_register_if.sv
// Control and status bundle of the processor status register.
// The control FSM/interrupt controller drive master; the PSR is the slave.
interface status_stack_register_if #(
  parameter int unsigned WORD  = 16,
  parameter int unsigned FLAGS = 4,
  parameter int unsigned PLVLS = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PW   = $clog2(PLVLS);
  localparam int unsigned CEXW = WORD - FLAGS - 2 - 2 * PW;
  localparam int unsigned DW   = $clog2(DEPTH + 1);

  logic [WORD/8-1:0] wrEn_i;
  logic [WORD-1:0]   data_i;
  logic [FLAGS-1:0]  wrFlags_i;
  logic [FLAGS-1:0]  flags_i;
  logic              clrSlp_i;
  logic              push_i;
  logic              pop_i;
  logic [PW-1:0]     priv_i;
  logic              cexLoad_i;
  logic [CEXW-1:0]   cexCnt_i;
  logic              cexStep_i;
  logic [WORD-1:0]   data_o;
  logic              ie_o;
  logic              cexActive_o;
  logic [DW-1:0]     depth_o;
  logic              ovf_o;
  logic              udf_o;
  logic              privErr_o;

  modport master (
    output wrEn_i, data_i, wrFlags_i, flags_i, clrSlp_i, push_i, pop_i, priv_i,
    output cexLoad_i, cexCnt_i, cexStep_i,
    input  data_o, ie_o, cexActive_o, depth_o, ovf_o, udf_o, privErr_o
  );

  modport slave (
    input  wrEn_i, data_i, wrFlags_i, flags_i, clrSlp_i, push_i, pop_i, priv_i,
    input  cexLoad_i, cexCnt_i, cexStep_i,
    output data_o, ie_o, cexActive_o, depth_o, ovf_o, udf_o, privErr_o
  );
endinterface

// File: rtl/status_stack_register.sv
// Processor status register with a save/restore stack for nested exceptions,
// a CEX down-counter and write-protected privilege fields.
module status_stack_register #(
  parameter int unsigned WORD  = 16,
  parameter int unsigned FLAGS = 4,
  parameter int unsigned PLVLS = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  status_stack_register_if.slave bus
);
  localparam int unsigned PW      = $clog2(PLVLS);
  localparam int unsigned CEXW    = WORD - FLAGS - 2 - 2 * PW;
  localparam int unsigned DW      = $clog2(DEPTH + 1);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SlpBit  = FLAGS;
  localparam int unsigned IeBit   = FLAGS + 1;
  localparam int unsigned CexLsb  = FLAGS + 2;
  localparam int unsigned PrevLsb = CexLsb + CEXW;
  localparam int unsigned CurrLsb = PrevLsb + PW;
  // PREV and CURR together occupy the top 2*PW bits of the word.
  localparam logic [WORD-1:0] PrivMask = {{(2 * PW){1'b1}}, {(WORD - 2 * PW){1'b0}}};
  localparam logic [DW-1:0]   DepthMax = DW'(DEPTH);

  logic [WORD-1:0] word_q, word_d;
  logic [WORD-1:0] src_word, lane_mask, wr_mask;
  logic [WORD-1:0] stack_q [DEPTH];
  logic [DW-1:0]   depth_q, depth_d, top_idx;
  logic [CEXW-1:0] cex_src;
  logic            ovf_q, ovf_d, udf_q, udf_d, priv_err_q, priv_err_d;
  logic            push_ok, curr_zero;

  assign push_ok   = bus.push_i && (depth_q < DepthMax);
  assign top_idx   = depth_q - DW'(1);
  assign curr_zero = (word_q[CurrLsb +: PW] == '0);

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < int'(WORD); b++) begin
      lane_mask[b] = bus.wrEn_i[b / 8];
    end
  end

  // Privilege bits are only software-writable from the most privileged level.
  assign wr_mask = curr_zero ? lane_mask : (lane_mask & ~PrivMask);

  // Field-level sources; byte lanes override these bit by bit.
  always_comb begin
    src_word = word_q;
    for (int i = 0; i < int'(FLAGS); i++) begin
      if (bus.wrFlags_i[i]) src_word[i] = bus.flags_i[i];
    end
    if (bus.clrSlp_i) src_word[SlpBit] = 1'b0;
    cex_src = word_q[CexLsb +: CEXW];
    if (bus.cexLoad_i) begin
      cex_src = bus.cexCnt_i;
    end else if (bus.cexStep_i && (cex_src != '0)) begin
      cex_src = cex_src - CEXW'(1);
    end
    src_word[CexLsb +: CEXW] = cex_src;
  end

  always_comb begin
    word_d     = word_q;
    depth_d    = depth_q;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    priv_err_d = 1'b0;
    if (bus.push_i) begin
      if (push_ok) begin
        depth_d                   = depth_q + DW'(1);
        word_d[CurrLsb +: PW]     = bus.priv_i;
        word_d[PrevLsb +: PW]     = word_q[CurrLsb +: PW];
        word_d[CexLsb +: CEXW]    = '0;
        word_d[IeBit]             = 1'b0;
        word_d[SlpBit]            = 1'b0;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.pop_i) begin
      if (depth_q != '0) begin
        word_d  = stack_q[top_idx[AW-1:0]];
        depth_d = top_idx;
      end else begin
        udf_d = 1'b1;
      end
    end else begin
      word_d     = (src_word & ~wr_mask) | (bus.data_i & wr_mask);
      priv_err_d = !curr_zero && (|(lane_mask & PrivMask));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q     <= '0;
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      priv_err_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      depth_q    <= depth_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      priv_err_q <= priv_err_d;
    end
  end

  // Stack contents need no reset: only entries below depth_q are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) stack_q[depth_q[AW-1:0]] <= word_q;
  end

  assign bus.data_o      = word_q;
  assign bus.ie_o        = word_q[IeBit];
  assign bus.cexActive_o = |word_q[CexLsb +: CEXW];
  assign bus.depth_o     = depth_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.udf_o       = udf_q;
  assign bus.privErr_o   = priv_err_q;
endmodule

// File: tb/tb_status_stack_register.sv
// Bench for status_stack_register: directed vector table, corner-case sequences
// and randomized traffic against a field/queue-level reference model.
module tb_status_stack_register;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  status_stack_register_if bus ();
  status_stack_register dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct {
    logic [1:0]  wr_en;
    logic [15:0] data;
    logic [3:0]  wr_flags;
    logic [3:0]  flags;
    logic        clr_slp, push, pop;
    logic [2:0]  priv;
    logic        cex_load;
    logic [3:0]  cex_cnt;
    logic        cex_step;
    logic [15:0] exp_data;
    logic [2:0]  exp_depth;
    logic        exp_ovf, exp_udf, exp_perr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // Reference model: whole word plus a queue holding the saved words.
  logic [15:0] m_w;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_udf, m_perr;

  function automatic vec_t mk(logic [1:0] we, logic [15:0] d, logic [3:0] wf, logic [3:0] f,
                              logic cs, logic pu, logic po, logic [2:0] pr, logic cl,
                              logic [3:0] cc, logic cst, logic [15:0] ed, logic [2:0] edp,
                              logic eo, logic eu, logic ep);
    vec_t v;
    v.wr_en = we; v.data = d; v.wr_flags = wf; v.flags = f; v.clr_slp = cs;
    v.push = pu; v.pop = po; v.priv = pr; v.cex_load = cl; v.cex_cnt = cc;
    v.cex_step = cst; v.exp_data = ed; v.exp_depth = edp;
    v.exp_ovf = eo; v.exp_udf = eu; v.exp_perr = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ed, input logic [2:0] edp,
                           input logic eo, input logic eu, input logic ep);
    chk({tag, " data_o"}, 32'(bus.data_o), 32'(ed));
    chk({tag, " ie_o"}, 32'(bus.ie_o), 32'(ed[5]));
    chk({tag, " cexActive_o"}, 32'(bus.cexActive_o), 32'(ed[9:6] != 4'h0));
    chk({tag, " depth_o"}, 32'(bus.depth_o), 32'(edp));
    chk({tag, " ovf_o"}, 32'(bus.ovf_o), 32'(eo));
    chk({tag, " udf_o"}, 32'(bus.udf_o), 32'(eu));
    chk({tag, " privErr_o"}, 32'(bus.privErr_o), 32'(ep));
  endtask

  task automatic apply(input vec_t v);
    bus.wrEn_i = v.wr_en; bus.data_i = v.data; bus.wrFlags_i = v.wr_flags;
    bus.flags_i = v.flags; bus.clrSlp_i = v.clr_slp; bus.push_i = v.push;
    bus.pop_i = v.pop; bus.priv_i = v.priv; bus.cexLoad_i = v.cex_load;
    bus.cexCnt_i = v.cex_cnt; bus.cexStep_i = v.cex_step;
  endtask

  task automatic idle();
    vec_t v;
    v = mk(2'b00, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 1'b0,
           16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    apply(v);
  endtask

  // Layout: C0..V3, SLP4, IE5, CEX[9:6], PREV[12:10], CURR[15:13].
  task automatic model_step();
    logic [15:0] n;
    logic [3:0]  cex;
    m_ovf = 1'b0; m_udf = 1'b0; m_perr = 1'b0;
    if (bus.push_i) begin
      if (m_stk.size() < 4) begin
        m_stk.push_back(m_w);
        m_w = {bus.priv_i, m_w[15:13], 4'h0, 1'b0, 1'b0, m_w[3:0]};
      end else m_ovf = 1'b1;
    end else if (bus.pop_i) begin
      if (m_stk.size() > 0) m_w = m_stk.pop_back();
      else m_udf = 1'b1;
    end else begin
      n = m_w;
      for (int i = 0; i < 4; i++) if (bus.wrFlags_i[i]) n[i] = bus.flags_i[i];
      if (bus.clrSlp_i) n[4] = 1'b0;
      cex = n[9:6];
      if (bus.cexLoad_i) cex = bus.cexCnt_i;
      else if (bus.cexStep_i && cex != 4'h0) cex = cex - 4'h1;
      n[9:6] = cex;
      if (bus.wrEn_i[0]) n[7:0] = bus.data_i[7:0];
      if (bus.wrEn_i[1]) begin
        if (m_w[15:13] == 3'd0) n[15:8] = bus.data_i[15:8];
        else begin
          n[9:8] = bus.data_i[9:8];
          m_perr = 1'b1;
        end
      end
      m_w = n;
    end
  endtask

  initial begin
    vec_t v;
    // Order: wr_en, data, wr_flags, flags, clr_slp, push, pop, priv, cex_load, cex_cnt,
    //        cex_step | exp_data, exp_depth, ovf, udf, perr
    vecs.push_back(mk(2'b01, 16'h002B, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h002B, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b11, 16'h2005, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h2005, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b10, 16'hFF00, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 0, 1));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd0, 0, 4'd0, 0, 16'h0405, 3'd1, 0, 0, 0));
    vecs.push_back(mk(2'b11, 16'h0027, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h0027, 3'd1, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd3, 0, 4'd0, 0, 16'h6007, 3'd2, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h0027, 3'd1, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 1, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd2, 0, 4'd0, 0, 16'h4405, 3'd1, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd5, 0, 4'd0, 0, 16'hA805, 3'd2, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd7, 0, 4'd0, 0, 16'hF405, 3'd3, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd1, 0, 4'd0, 0, 16'h3C05, 3'd4, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 0, 3'd0, 0, 4'd0, 0, 16'h3C05, 3'd4, 1, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'hF405, 3'd3, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'hA805, 3'd2, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h4405, 3'd1, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 1, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 1, 1, 3'd0, 0, 4'd0, 0, 16'h0405, 3'd1, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 1, 3'd0, 0, 4'd0, 0, 16'h2305, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 3'd0, 1, 4'd2, 0, 16'h2085, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 1, 16'h2045, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 1, 16'h2005, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 1, 16'h2005, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 0, 0, 0, 3'd0, 1, 4'd5, 1, 16'h2145, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 16'h0000, 4'h1, 4'h1, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h2100, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'hF, 4'hA, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h210A, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 16'h001A, 4'h0, 4'h0, 0, 0, 0, 3'd0, 0, 4'd0, 0, 16'h211A, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 16'h0000, 4'h0, 4'h0, 1, 0, 0, 3'd0, 0, 4'd0, 0, 16'h210A, 3'd0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 16'h0010, 4'h0, 4'h0, 1, 0, 0, 3'd0, 0, 4'd0, 0, 16'h2110, 3'd0, 0, 0, 0));

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk) apply(vecs[i]);
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_depth,
                   vecs[i].exp_ovf, vecs[i].exp_udf, vecs[i].exp_perr);
    end

    // Push, then assert reset in the middle of a second push.
    @(negedge clk) idle();
    bus.push_i = 1'b1; bus.priv_i = 3'd4;
    @(posedge clk);
    #1 check_all("pre_rst_push", 16'h8400, 3'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk) bus.priv_i = 3'd2;
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_all("rst_hold", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) begin
      idle();
      rst_n = 1'b1;
    end
    @(posedge clk);
    #1 check_all("post_rst", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

    m_w = 16'h0000;
    m_stk.delete();
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      idle();
      bus.push_i    = (r < 20);
      bus.pop_i     = (r >= 15 && r < 42);
      bus.priv_i    = 3'($urandom);
      bus.wrEn_i    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      bus.data_i    = 16'($urandom);
      bus.wrFlags_i = 4'($urandom);
      bus.flags_i   = 4'($urandom);
      bus.clrSlp_i  = ($urandom_range(0, 3) == 0);
      bus.cexLoad_i = ($urandom_range(0, 5) == 0);
      bus.cexCnt_i  = 4'($urandom);
      bus.cexStep_i = ($urandom_range(0, 1) == 0);
      model_step();
      @(posedge clk);
      #1 check_all($sformatf("rnd%0d", c), m_w, 3'(m_stk.size()), m_ovf, m_udf, m_perr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
